q_meas_sequencer: RTL

- Plant-side counterpart of the secant current-reference controller.
- Takes the controller's i_ref code and forwards it to the DAC as dac_code.
- Waits a programmable settling time, then runs 2^AVG_LOG2 ADC conversions through a start/done handshake and averages them.
- Returns q_measured with a one-cycle ready pulse, which is the ready the controller uses to advance its state.

---
 rtl/q_meas_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/q_meas_sequencer.sv
// Measurement sequencer: forwards the current-reference code to the DAC, waits for the
// analog path to settle, averages 2^AVG_LOG2 ADC conversions and returns the result with
// a one-cycle ready pulse.
module q_meas_sequencer #(
    parameter int unsigned BUS_WIDTH     = 10,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned AVG_LOG2      = 2,
    parameter int unsigned TIMEOUT       = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] i_ref,
    input  logic                 start,
    input  logic [BUS_WIDTH-1:0] adc_data,
    input  logic                 adc_done,
    output logic                 adc_start,
    output logic [BUS_WIDTH-1:0] dac_code,
    output logic [BUS_WIDTH-1:0] q_measured,
    output logic                 ready,
    output logic                 busy,
    output logic                 adc_timeout
);

    localparam int unsigned NumSamples = 1 << AVG_LOG2;
    localparam int unsigned AccW       = BUS_WIDTH + AVG_LOG2;
    localparam int unsigned CntW       = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned SettleW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned TmoW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StConvert,
        StWait,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [SettleW-1:0]   settle_q, settle_d;
    logic [TmoW-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic [CntW-1:0]      smp_q, smp_d;
    logic [AccW-1:0]      acc_q, acc_d;
    logic [BUS_WIDTH-1:0] dac_q, dac_d;
    logic [BUS_WIDTH-1:0] last_q, last_d;
    logic [BUS_WIDTH-1:0] q_q, q_d;
    logic                 ready_q, ready_d;
    logic                 timeout_q, timeout_d;

    // State and datapath registers, synchronous reset aborts any measurement in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            settle_q  <= '0;
            tmo_cnt_q <= '0;
            smp_q     <= '0;
            acc_q     <= '0;
            dac_q     <= '0;
            last_q    <= '0;
            q_q       <= '0;
            ready_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            tmo_cnt_q <= tmo_cnt_d;
            smp_q     <= smp_d;
            acc_q     <= acc_d;
            dac_q     <= dac_d;
            last_q    <= last_d;
            q_q       <= q_d;
            ready_q   <= ready_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state and datapath updates for the settle/convert/average sequence.
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        tmo_cnt_d = tmo_cnt_q;
        smp_d     = smp_q;
        acc_d     = acc_q;
        dac_d     = dac_q;
        last_d    = last_q;
        q_d       = q_q;
        ready_d   = 1'b0;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                // i_ref changes seen while busy are caught here because last_q is stale.
                if ((i_ref != last_q) || start) begin
                    dac_d    = i_ref;
                    last_d   = i_ref;
                    acc_d    = '0;
                    smp_d    = '0;
                    settle_d = SettleW'(SETTLE_CYCLES - 1);
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                if (settle_q == '0) begin
                    state_d = StConvert;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            StConvert: begin
                tmo_cnt_d = '0;
                state_d   = StWait;
            end
            StWait: begin
                if (adc_done) begin
                    acc_d = acc_q + AccW'(adc_data);
                    if (smp_q == CntW'(NumSamples - 1)) begin
                        state_d = StDone;
                    end else begin
                        smp_d   = smp_q + 1'b1;
                        state_d = StConvert;
                    end
                end else if (tmo_cnt_q == TmoW'(TIMEOUT - 1)) begin
                    // Abort: report ready so the controller advances, keep the old result.
                    ready_d   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            StDone: begin
                q_d     = BUS_WIDTH'(acc_q >> AVG_LOG2);
                ready_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign adc_start   = (state_q == StConvert);
    assign busy        = (state_q != StIdle);
    assign dac_code    = dac_q;
    assign q_measured  = q_q;
    assign ready       = ready_q;
    assign adc_timeout = timeout_q;

endmodule
